// File: rtl/regfile_wb_queue.sv
// ============================================================================
// Module   : regfile_wb_queue
// Brief    : Register-file writeback FIFO that drains one entry per cycle and
//            forwards the youngest pending write to decode-stage lookups.
//            Optional same-cycle bypass when empty: define WBQ_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_queue #(
    parameter int REG_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rd,
    input  logic [REG_WIDTH-1:0]   in_data,
    output logic [4:0]             rf_rd,
    output logic [REG_WIDTH-1:0]   rf_rd_din,
    output logic                   rf_reg_write,
    input  logic [4:0]             fwd_rs1,
    input  logic [4:0]             fwd_rs2,
    output logic                   fwd_rs1_hit,
    output logic                   fwd_rs2_hit,
    output logic [REG_WIDTH-1:0]   fwd_rs1_data,
    output logic [REG_WIDTH-1:0]   fwd_rs2_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]        r_head;
    logic [AW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic [4:0]           r_rd_mem   [DEPTH];
    logic [REG_WIDTH-1:0] r_data_mem [DEPTH];

    logic                 w_full;
    logic                 w_empty;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic [AW-1:0]        w_fwd_idx;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign count    = r_count;

`ifdef WBQ_BYPASS_EN
    // An empty queue hands a request straight to the register file instead of storing it.
    assign w_bypass = w_empty && in_valid && (in_rd != 5'd0) && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = in_valid && !w_full && (in_rd != 5'd0) && !w_bypass;
    // The register file never stalls, so the head retires every cycle it exists.
    assign w_pop  = !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_rd_mem[r_tail]   <= in_rd;
            r_data_mem[r_tail] <= in_data;
        end
    end

    always_comb begin
        rf_reg_write = 1'b0;
        rf_rd        = 5'd0;
        rf_rd_din    = '0;
        if (!w_empty) begin
            rf_reg_write = 1'b1;
            rf_rd        = r_rd_mem[r_head];
            rf_rd_din    = r_data_mem[r_head];
        end else if (w_bypass) begin
            rf_reg_write = 1'b1;
            rf_rd        = in_rd;
            rf_rd_din    = in_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_rs1_hit  = 1'b0;
        fwd_rs2_hit  = 1'b0;
        fwd_rs1_data = '0;
        fwd_rs2_data = '0;
        w_fwd_idx    = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_head + AW'(i);
            if (CW'(i) < r_count) begin
                if ((fwd_rs1 != 5'd0) && (r_rd_mem[w_fwd_idx] == fwd_rs1)) begin
                    fwd_rs1_hit  = 1'b1;
                    fwd_rs1_data = r_data_mem[w_fwd_idx];
                end
                if ((fwd_rs2 != 5'd0) && (r_rd_mem[w_fwd_idx] == fwd_rs2)) begin
                    fwd_rs2_hit  = 1'b1;
                    fwd_rs2_data = r_data_mem[w_fwd_idx];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
// ============================================================================
// Module   : tb_regfile_wb_queue
// Brief    : Randomized and directed checks of regfile_wb_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_queue;

    localparam int REG_WIDTH = 32;
    localparam int DEPTH     = 4;
    localparam int CW        = $clog2(DEPTH) + 1;

    typedef struct {
        logic [4:0]           rd;
        logic [REG_WIDTH-1:0] data;
    } entry_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rd;
    logic [REG_WIDTH-1:0] in_data;
    logic [4:0]           rf_rd;
    logic [REG_WIDTH-1:0] rf_rd_din;
    logic                 rf_reg_write;
    logic [4:0]           fwd_rs1;
    logic [4:0]           fwd_rs2;
    logic                 fwd_rs1_hit;
    logic                 fwd_rs2_hit;
    logic [REG_WIDTH-1:0] fwd_rs1_data;
    logic [REG_WIDTH-1:0] fwd_rs2_data;
    logic [CW-1:0]        count;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t model_q[$];
    int     max_count = 0;

    regfile_wb_queue #(.REG_WIDTH(REG_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .rf_rd(rf_rd), .rf_rd_din(rf_rd_din), .rf_reg_write(rf_reg_write),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest pending write to register r, searched from the tail backwards.
    task automatic model_fwd(input logic [4:0] r, output logic hit, output logic [REG_WIDTH-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != 5'd0) begin
            for (int k = model_q.size() - 1; k >= 0; k--) begin
                if (model_q[k].rd == r) begin
                    hit = 1'b1;
                    d   = model_q[k].data;
                    break;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
    task automatic step(input logic r, input logic v, input logic [4:0] rd,
                        input logic [REG_WIDTH-1:0] d, input logic [4:0] s1, input logic [4:0] s2);
        logic                 exp_we;
        logic [4:0]           exp_rd;
        logic [REG_WIDTH-1:0] exp_din;
        logic                 h1, h2;
        logic [REG_WIDTH-1:0] d1, d2;
        logic                 bypass;
        logic                 ready;
        rst = r; in_valid = v; in_rd = rd; in_data = d; fwd_rs1 = s1; fwd_rs2 = s2;
        #1;
        ready   = (model_q.size() != DEPTH);
        bypass  = 1'b0;
        exp_we  = 1'b0;
        exp_rd  = '0;
        exp_din = '0;
        if (model_q.size() != 0) begin
            exp_we = 1'b1; exp_rd = model_q[0].rd; exp_din = model_q[0].data;
        end
`ifdef WBQ_BYPASS_EN
        else if (v && rd != 5'd0 && !r) begin
            bypass = 1'b1;
            exp_we = 1'b1; exp_rd = rd; exp_din = d;
        end
`endif
        model_fwd(s1, h1, d1);
        model_fwd(s2, h2, d2);
        check_eq("in_ready", 64'(in_ready), 64'(ready));
        check_eq("count", 64'(count), 64'(model_q.size()));
        check_eq("rf_reg_write", 64'(rf_reg_write), 64'(exp_we));
        check_eq("rf_rd", 64'(rf_rd), 64'(exp_rd));
        check_eq("rf_rd_din", 64'(rf_rd_din), 64'(exp_din));
        check_eq("fwd_rs1_hit", 64'(fwd_rs1_hit), 64'(h1));
        check_eq("fwd_rs1_data", 64'(fwd_rs1_data), 64'(d1));
        check_eq("fwd_rs2_hit", 64'(fwd_rs2_hit), 64'(h2));
        check_eq("fwd_rs2_data", 64'(fwd_rs2_data), 64'(d2));
        if (int'(count) > max_count) max_count = int'(count);
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            if (model_q.size() != 0) void'(model_q.pop_front());
            if (v && ready && rd != 5'd0 && !bypass) model_q.push_back('{rd: rd, data: d});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; fwd_rs1 = '0; fwd_rs2 = '0;
        @(posedge clk);
        @(negedge clk);
        // Reset state and the reset edge itself swallowing a request.
        step(1'b1, 1'b1, 5'd7, 32'hCAFE_0000, 5'd7, 5'd0);
        idle(1);

        // Single writeback to r5.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        check_eq("single_rf_rd", 64'(rf_rd), 64'd5);
        idle(2);

        // Writes to r0 are accepted and dropped.
        step(1'b0, 1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0);
        check_eq("r0_count", 64'(count), 64'd0);
        check_eq("r0_no_write", 64'(rf_reg_write), 64'd0);
        idle(1);

        // Back-to-back writes to r3; forwarding must track the youngest.
        step(1'b0, 1'b1, 5'd3, 32'h11, 5'd3, 5'd3);
        step(1'b0, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
        step(1'b0, 1'b0, 5'd0, '0,     5'd3, 5'd3);
        step(1'b0, 1'b0, 5'd0, '0,     5'd3, 5'd3);

        // Continuous stream of ten requests, wrapping the pointers.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 5'(k + 1), 32'(k * 17 + 1), 5'(k), 5'(k + 1));
        idle(2);

        // Reset while an entry is draining.
        step(1'b0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
        step(1'b1, 1'b1, 5'd10, 32'hAA, 5'd9, 5'd10);
        check_eq("post_rst_pending", 64'(model_q.size()), 64'd0);
        step(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd10);

        // Randomized traffic with occasional resets and narrow register space.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(2);

        // Without backpressure the queue never holds more than one entry.
        check_eq("max_count_le_1", 64'(max_count <= 1), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
